// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Single-requester SPI frame sequencer for the SPI slave + single-port RAM
//   wrapper. Turns one host request {op, byte} into one SPI frame on
//   SS_n/MOSI, and for read-data frames (op 11) captures the returned byte
//   from MISO. The SPI bit clock is the system clock: SS_n/MOSI change on
//   posedge clk and MISO is sampled on posedge clk.
//
//   Optional build macro SPI_RAM_MASTER_AUTO_READ_EN: an accepted rd-addr
//   frame is followed automatically by a rd-data frame (op 11, data 8'h00)
//   without returning to IDLE.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   req_valid/req_ready   host handshake (ready only in IDLE)
//   req_op, req_data      00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data; byte
//   rsp_valid, rsp_data   one-cycle pulse with the captured read byte
//   busy                  high whenever not IDLE
//   rd_seq_err            sticky: rd-data issued without a preceding rd-addr
//   SS_n, MOSI, MISO      SPI pins (MSB first)
module spi_ram_master #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       rd_seq_err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_CMD, S_SHIFT, S_TAIL, S_WAIT, S_CAPTURE, S_GAP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [9:0] sh_q, sh_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] wg_cnt_q, wg_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rd_frame_q, rd_frame_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
  logic       auto_q, auto_d;
`endif
  logic       accept;

  assign req_ready  = (state_q == S_IDLE) && rst_n;
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rd_seq_err = err_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    wg_cnt_d    = wg_cnt_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rd_frame_d  = rd_frame_q;
    pend_d      = pend_q;
    err_d       = err_q;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
    auto_d      = auto_q;
`endif
    SS_n        = 1'b1;
    MOSI        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_SEL;
          sh_d       = {req_op, req_data};
          rd_frame_d = (req_op == 2'b11);
          if (req_op == 2'b10) pend_d = 1'b1;
          if (req_op == 2'b11) begin
            pend_d = 1'b0;
            if (!pend_q) err_d = 1'b1;
          end
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
          auto_d = (req_op == 2'b10);
`endif
        end
      end
      S_SEL: begin
        SS_n    = 1'b0;
        state_d = S_CMD;
      end
      S_CMD: begin
        // Command bit is op[1]; the shift register is not advanced here,
        // so op[1] goes out again as the first SHIFT bit.
        SS_n      = 1'b0;
        MOSI      = sh_q[9];
        bit_cnt_d = 4'd0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        SS_n      = 1'b0;
        MOSI      = sh_q[9];
        sh_d      = {sh_q[8:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = 4'd0;
          wg_cnt_d  = 4'd0;
          state_d   = rd_frame_q ? S_WAIT : S_TAIL;
        end
      end
      S_TAIL: begin
        SS_n     = 1'b0;
        wg_cnt_d = 4'd0;
        state_d  = S_GAP;
      end
      S_WAIT: begin
        SS_n = 1'b0;
        if (wg_cnt_q == WAIT_LAST) begin
          bit_cnt_d = 4'd0;
          state_d   = S_CAPTURE;
        end else begin
          wg_cnt_d = wg_cnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        SS_n = 1'b0;
        rx_d = {rx_q[6:0], MISO};
        if (bit_cnt_q == 4'd7) begin
          rsp_data_d  = rx_d;
          rsp_valid_d = 1'b1;
          wg_cnt_d    = 4'd0;
          state_d     = S_GAP;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (wg_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
          // Chain the rd-data frame straight after the rd-addr gap; it
          // consumes the pending rd-addr so no sequence error can arise.
          if (auto_q) begin
            state_d    = S_SEL;
            sh_d       = {2'b11, 8'h00};
            rd_frame_d = 1'b1;
            pend_d     = 1'b0;
            auto_d     = 1'b0;
          end
`endif
        end else begin
          wg_cnt_d = wg_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      wg_cnt_q    <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rd_frame_q  <= 1'b0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
      auto_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      wg_cnt_q    <= wg_cnt_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rd_frame_q  <= rd_frame_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
`ifdef SPI_RAM_MASTER_AUTO_READ_EN
      auto_q      <= auto_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
module tb_spi_ram_master;
  localparam int RW  = 2;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       rd_seq_err;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  spi_ram_master #(.READ_WAIT(RW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .rd_seq_err(rd_seq_err),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         len;
    logic [10:0] bits;
    bit         zbad;
  } frame_t;
  frame_t frames[$];

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    int          len;
    logic [10:0] bits;
    int          nrsp;
    logic [7:0]  rd;
    bit          err;
  } vec_t;
  vec_t vecs[9];

  // Bench-side SPI slave + RAM: decodes MOSI frames and serves MISO.
  int          low_cnt = 0;
  logic [10:0] cur_bits = '0;
  bit          cur_zbad = 0;
  bit          s_rd = 0;
  logic [7:0]  s_ram[256];
  logic [7:0]  s_waddr = 8'h00;
  logic [7:0]  s_raddr = 8'h00;
  logic [7:0]  s_byte = 8'h00;
  int          rsp_cnt = 0;
  logic [7:0]  last_rsp = 8'h00;

  // Reference model of the request stream.
  logic [7:0]  ref_ram[256];
  logic [7:0]  ref_waddr = 8'h00;
  logic [7:0]  ref_raddr = 8'h00;
  bit          ref_pend = 0;
  bit          ref_err = 0;

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (low_cnt >= 1 && low_cnt <= 11) cur_bits = {cur_bits[9:0], MOSI};
      else if (MOSI !== 1'b0) cur_zbad = 1'b1;
      if (low_cnt == 12) begin
        case (cur_bits[9:8])
          2'b00: s_waddr = cur_bits[7:0];
          2'b01: s_ram[s_waddr] = cur_bits[7:0];
          2'b10: s_raddr = cur_bits[7:0];
          default: begin s_byte = s_ram[s_raddr]; s_rd = 1'b1; end
        endcase
      end
      if (s_rd && low_cnt >= 12 + RW && low_cnt <= 19 + RW)
        MISO = s_byte[3'(19 + RW - low_cnt)];
      else
        MISO = 1'b0;
      low_cnt++;
    end else begin
      MISO = 1'b0;
      if (low_cnt > 0) begin
        frames.push_back('{low_cnt, cur_bits, cur_zbad});
        low_cnt = 0; cur_bits = '0; cur_zbad = 0; s_rd = 0;
      end
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_rsp = rsp_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic ref_apply(input logic [1:0] op, input logic [7:0] data, output int len,
                           output logic [10:0] bits, output int nrsp, output logic [7:0] rd,
                           output bit err);
    bits = {op[1], op, data};
    len  = (op == 2'b11) ? 20 + RW : 13;
    nrsp = (op == 2'b11) ? 1 : 0;
    rd   = ref_ram[ref_raddr];
    case (op)
      2'b00: ref_waddr = data;
      2'b01: ref_ram[ref_waddr] = data;
      2'b10: begin ref_raddr = data; ref_pend = 1; end
      default: begin if (!ref_pend) ref_err = 1; ref_pend = 0; end
    endcase
    err = ref_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ss_n", 32'(SS_n), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(rd_seq_err), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_after", 32'(req_ready), 1);
    frames.delete();
    ref_pend = 0;
    ref_err = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    bit got;
    got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = data;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (req_ready === 1'b1) begin
        @(posedge clk);
        #1;
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [7:0] data, input int len,
                         input logic [10:0] bits, input int nrsp, input logic [7:0] rd,
                         input bit err, input string tag);
    int r0;
    frame_t f;
    frames.delete();
    r0 = rsp_cnt;
    issue(op, data);
    wait_idle();
    chk({tag, "_nframes"}, frames.size(), 1);
    if (frames.size() > 0) begin
      f = frames.pop_front();
      chk({tag, "_ss_low_len"}, f.len, len);
      chk({tag, "_mosi_bits"}, 32'(f.bits), 32'(bits));
      chk({tag, "_mosi_idle_zero"}, 32'(f.zbad), 0);
    end
    chk({tag, "_nrsp"}, rsp_cnt - r0, nrsp);
    if (nrsp != 0) chk({tag, "_rsp_data"}, 32'(last_rsp), 32'(rd));
    chk({tag, "_rd_seq_err"}, 32'(rd_seq_err), 32'(err));
  endtask

  int          e_len, e_nrsp, r0, n_acc, viol;
  logic [10:0] e_bits;
  logic [7:0]  e_rd, r_data;
  logic [1:0]  r_op;
  bit          e_err;
  int          t_acc[3];
  logic [7:0]  bp[3];
  frame_t      f0;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin s_ram[i] = 8'h00; ref_ram[i] = 8'h00; end
    do_reset();

`ifdef SPI_RAM_MASTER_AUTO_READ_EN
    run_req(2'b00, 8'h3A, 13, 11'h03A, 0, 8'h00, 1'b0, "a_wa");
    run_req(2'b01, 8'hC5, 13, 11'h1C5, 0, 8'h00, 1'b0, "a_wd");
    frames.delete();
    r0 = rsp_cnt;
    issue(2'b10, 8'h3A);
    wait_idle();
    chk("auto_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      f0 = frames.pop_front();
      chk("auto_f0_len", f0.len, 13);
      chk("auto_f0_bits", 32'(f0.bits), 32'h63A);
      f0 = frames.pop_front();
      chk("auto_f1_len", f0.len, 20 + RW);
      chk("auto_f1_bits", 32'(f0.bits), 32'h700);
    end
    chk("auto_nrsp", rsp_cnt - r0, 1);
    chk("auto_rsp_data", 32'(last_rsp), 32'hC5);
    chk("auto_err", 32'(rd_seq_err), 0);
`else
    vecs[0] = '{2'b00, 8'h3A, 13,      11'h03A, 0, 8'h00, 1'b0};
    vecs[1] = '{2'b01, 8'hC5, 13,      11'h1C5, 0, 8'h00, 1'b0};
    vecs[2] = '{2'b10, 8'h3A, 13,      11'h63A, 0, 8'h00, 1'b0};
    vecs[3] = '{2'b11, 8'h00, 20 + RW, 11'h700, 1, 8'hC5, 1'b0};
    vecs[4] = '{2'b00, 8'h07, 13,      11'h007, 0, 8'h00, 1'b0};
    vecs[5] = '{2'b01, 8'h5A, 13,      11'h15A, 0, 8'h00, 1'b0};
    vecs[6] = '{2'b10, 8'h07, 13,      11'h607, 0, 8'h00, 1'b0};
    vecs[7] = '{2'b10, 8'h3A, 13,      11'h63A, 0, 8'h00, 1'b0};
    vecs[8] = '{2'b11, 8'hFF, 20 + RW, 11'h7FF, 1, 8'hC5, 1'b0};
    for (int i = 0; i < 9; i++) begin
      ref_apply(vecs[i].op, vecs[i].data, e_len, e_bits, e_nrsp, e_rd, e_err);
      run_req(vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].bits, vecs[i].nrsp,
              vecs[i].rd, vecs[i].err, $sformatf("vec%0d", i));
    end

    // rd-data straight after reset: frame still runs, error is sticky.
    do_reset();
    ref_apply(2'b11, 8'h00, e_len, e_bits, e_nrsp, e_rd, e_err);
    run_req(2'b11, 8'h00, 20 + RW, 11'h700, 1, 8'hC5, 1'b1, "seq_rd");
    ref_apply(2'b10, 8'h07, e_len, e_bits, e_nrsp, e_rd, e_err);
    run_req(2'b10, 8'h07, 13, 11'h607, 0, 8'h00, 1'b1, "seq_ra");
    ref_apply(2'b11, 8'h00, e_len, e_bits, e_nrsp, e_rd, e_err);
    run_req(2'b11, 8'h00, 20 + RW, 11'h700, 1, 8'h5A, 1'b1, "seq_rd2");

    // Reset asserted during the 5th SHIFT cycle of a wr-addr frame.
    frames.delete();
    r0 = rsp_cnt;
    issue(2'b00, 8'h55);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_ss_n", 32'(SS_n), 1);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_err_cleared", 32'(rd_seq_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_nframes", frames.size(), 1);
    if (frames.size() > 0) begin
      f0 = frames.pop_front();
      chk("mr_abort_len", f0.len, 7);
    end
    chk("mr_no_rsp", rsp_cnt - r0, 0);
    ref_pend = 0;
    ref_err = 0;
    ref_apply(2'b01, 8'hA5, e_len, e_bits, e_nrsp, e_rd, e_err);
    run_req(2'b01, 8'hA5, 13, 11'h1A5, 0, 8'h00, 1'b0, "mr_wd");
    ref_apply(2'b10, 8'h07, e_len, e_bits, e_nrsp, e_rd, e_err);
    run_req(2'b10, 8'h07, 13, 11'h607, 0, 8'h00, 1'b0, "mr_ra");
    ref_apply(2'b11, 8'h00, e_len, e_bits, e_nrsp, e_rd, e_err);
    run_req(2'b11, 8'h00, 20 + RW, 11'h700, 1, 8'hA5, 1'b0, "mr_rd");

    // Backpressure: req_valid held high across three queued writes.
    bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33;
    n_acc = 0;
    viol = 0;
    @(negedge clk);
    frames.delete();
    req_valid = 1'b1; req_op = 2'b01; req_data = bp[0];
    for (int i = 0; i < 300 && n_acc < 3; i++) begin
      #1;
      if (req_ready === 1'b1) begin
        t_acc[n_acc] = cyc;
        n_acc++;
        @(posedge clk);
        #1;
        if (n_acc < 3) req_data = bp[n_acc];
        else req_valid = 1'b0;
      end else if (busy !== 1'b1) begin
        viol++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepts", n_acc, 3);
    chk("bp_space1", t_acc[1] - t_acc[0], 14 + GAP);
    chk("bp_space2", t_acc[2] - t_acc[1], 14 + GAP);
    chk("bp_ready_low_busy_high", viol, 0);
    wait_idle();
    chk("bp_nframes", frames.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (frames.size() > 0) begin
        f0 = frames.pop_front();
        chk($sformatf("bp_len%0d", k), f0.len, 13);
        chk($sformatf("bp_bits%0d", k), 32'(f0.bits), 32'({1'b0, 2'b01, bp[k]}));
      end
      ref_apply(2'b01, bp[k], e_len, e_bits, e_nrsp, e_rd, e_err);
    end

    // Randomized requests against the reference model.
    for (int k = 0; k < 40; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_data = (r_op[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      ref_apply(r_op, r_data, e_len, e_bits, e_nrsp, e_rd, e_err);
      run_req(r_op, r_data, e_len, e_bits, e_nrsp, e_rd, e_err, $sformatf("rnd%0d", k));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
